// File: rtl/dp_pkg.sv
// Shared types and constants for the datapath issue stage.
//   OPCODE_W    : opcode width
//   DP_N        : default operand width used by dp_triple_t
//   opcode_t    : operation code
//   dp_triple_t : one operand triple {a, b, opcode} at the default width
//   triple_width: packed width of a triple for an arbitrary operand width
package dp_pkg;

    localparam int OPCODE_W = 3;
    localparam int DP_N     = 16;

    typedef logic [OPCODE_W-1:0] opcode_t;

    typedef struct packed {
        logic [DP_N-1:0] a;
        logic [DP_N-1:0] b;
        opcode_t         opcode;
    } dp_triple_t;

    function automatic int triple_width(input int n);
        return (2 * n) + OPCODE_W;
    endfunction

endpackage

// File: rtl/dp_sync_fifo.sv
// Synchronous FIFO holding operand triples for the issue stage.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request and data (ignored while full)
//   pop, rdata    : read request (ignored while empty) and head entry
//   full, empty   : occupancy flags
//   count         : current occupancy, 0..DEPTH
module dp_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 35
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1'b1);
            2'b01:   count_d = count_q - (AW+1)'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Storage write at the current write pointer.
    always_comb begin
        mem_d = mem_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless once count is cleared, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dp_issue_stage.sv
// Issue stage feeding the arithmetic datapath.
// Buffers {A, B, opcode} triples in a FIFO, issues at most one per clock into
// registered dp_* outputs, and carries a valid/opcode tag through a delay line
// of PIPE stages so each datapath result is flagged and tagged.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_opcode : loader handshake and triple
//   issue_en                          : allows issuing from the FIFO
//   dp_a/dp_b/dp_opcode               : registered operands to the datapath
//   dp_y/dp_co                        : datapath result
//   res_valid/res_y/res_co/res_opcode : result with aligned tag
//   fifo_count                        : FIFO occupancy
//   idle                              : FIFO empty and no tag in flight
module dp_issue_stage
    import dp_pkg::*;
#(
    parameter int N     = 16,
    parameter int PIPE  = 1,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N-1:0]              in_a,
    input  logic [N-1:0]              in_b,
    input  logic [OPCODE_W-1:0]       in_opcode,
    input  logic                      issue_en,
    output logic [N-1:0]              dp_a,
    output logic [N-1:0]              dp_b,
    output logic [OPCODE_W-1:0]       dp_opcode,
    input  logic [N-1:0]              dp_y,
    input  logic                      dp_co,
    output logic                      res_valid,
    output logic [N-1:0]              res_y,
    output logic                      res_co,
    output logic [OPCODE_W-1:0]       res_opcode,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      idle
);

    localparam int TW = triple_width(N);

    logic [TW-1:0] fifo_rdata_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic          tag_busy_s;

    logic [N-1:0]  dp_a_q, dp_a_d;
    logic [N-1:0]  dp_b_q, dp_b_d;
    opcode_t       dp_op_q, dp_op_d;
    logic          issue_v_q, issue_v_d;

    assign in_ready = ~fifo_full_s;
    assign push_s   = in_valid & ~fifo_full_s;
    // No empty bypass: only entries already in the FIFO can be issued.
    assign pop_s    = issue_en & ~fifo_empty_s;

    dp_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata ({in_a, in_b, in_opcode}),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    // Issue register: load the FIFO head on a pop, otherwise hold operands.
    always_comb begin
        dp_a_d    = dp_a_q;
        dp_b_d    = dp_b_q;
        dp_op_d   = dp_op_q;
        issue_v_d = 1'b0;
        if (pop_s) begin
            {dp_a_d, dp_b_d, dp_op_d} = fifo_rdata_s;
            issue_v_d                 = 1'b1;
        end else begin
            issue_v_d = 1'b0;
        end
    end

    // Issue register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_a_q    <= '0;
            dp_b_q    <= '0;
            dp_op_q   <= '0;
            issue_v_q <= 1'b0;
        end else begin
            dp_a_q    <= dp_a_d;
            dp_b_q    <= dp_b_d;
            dp_op_q   <= dp_op_d;
            issue_v_q <= issue_v_d;
        end
    end

    assign dp_a      = dp_a_q;
    assign dp_b      = dp_b_q;
    assign dp_opcode = dp_op_q;

    generate
        if (PIPE > 0) begin : g_tag
            logic    [PIPE-1:0] tag_v_q, tag_v_d;
            opcode_t [PIPE-1:0] tag_op_q, tag_op_d;

            // Shift the issue tag one stage per clock regardless of issue_en.
            always_comb begin
                tag_v_d     = tag_v_q;
                tag_op_d    = tag_op_q;
                tag_v_d[0]  = issue_v_q;
                tag_op_d[0] = dp_op_q;
                for (int i = 1; i < PIPE; i++) begin
                    tag_v_d[i]  = tag_v_q[i-1];
                    tag_op_d[i] = tag_op_q[i-1];
                end
            end

            // Tag delay line registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_v_q  <= '0;
                    tag_op_q <= '0;
                end else begin
                    tag_v_q  <= tag_v_d;
                    tag_op_q <= tag_op_d;
                end
            end

            assign res_valid  = tag_v_q[PIPE-1];
            assign res_opcode = tag_op_q[PIPE-1];
            assign tag_busy_s = |tag_v_q;
        end else begin : g_no_tag
            // Combinational datapath: the result belongs to the triple just issued.
            assign res_valid  = issue_v_q;
            assign res_opcode = dp_op_q;
            assign tag_busy_s = 1'b0;
        end
    endgenerate

    assign res_y  = dp_y;
    assign res_co = dp_co;
    assign idle   = fifo_empty_s & ~issue_v_q & ~tag_busy_s;

endmodule

// File: tb/tb_dp_issue_stage.sv
// Self-checking bench for dp_issue_stage. Three instances (PIPE = 0, 1, 3)
// share one stimulus stream; each is driven by a behavioural datapath of its
// own latency. A queue-based model predicts issue order, occupancy and result
// timing from the pop history.
module tb_dp_issue_stage;

    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int NI    = 3;
    localparam int HMAX  = 4096;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   op;
    } trip_t;

    function automatic logic [N:0] dp_f(input logic [N-1:0] a, input logic [N-1:0] b,
                                        input logic [2:0] op);
        logic [N:0] r;
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {a, 1'b0};
            3'd6:    r = {1'b0, ~a};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    function automatic int pipe_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    logic clk = 1'b0;
    logic rst, in_valid, issue_en;
    logic [N-1:0] in_a, in_b;
    logic [2:0]   in_op;

    logic [NI-1:0]        in_ready_w, res_valid_w, res_co_w, idle_w, dp_co_w;
    logic [NI-1:0][N-1:0] dp_a_w, dp_b_w, dp_y_w, res_y_w;
    logic [NI-1:0][2:0]   dp_op_w, res_op_w;
    logic [NI-1:0][3:0]   cnt_w;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            localparam int PP = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
            dp_issue_stage #(.N(N), .PIPE(PP), .DEPTH(DEPTH)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid),
                .in_ready   (in_ready_w[g]),
                .in_a       (in_a),
                .in_b       (in_b),
                .in_opcode  (in_op),
                .issue_en   (issue_en),
                .dp_a       (dp_a_w[g]),
                .dp_b       (dp_b_w[g]),
                .dp_opcode  (dp_op_w[g]),
                .dp_y       (dp_y_w[g]),
                .dp_co      (dp_co_w[g]),
                .res_valid  (res_valid_w[g]),
                .res_y      (res_y_w[g]),
                .res_co     (res_co_w[g]),
                .res_opcode (res_op_w[g]),
                .fifo_count (cnt_w[g]),
                .idle       (idle_w[g])
            );
            if (PP == 0) begin : g_comb
                assign {dp_co_w[g], dp_y_w[g]} = dp_f(dp_a_w[g], dp_b_w[g], dp_op_w[g]);
            end else begin : g_seq
                logic [N:0] dl [PP];
                always @(posedge clk) begin
                    dl[0] <= dp_f(dp_a_w[g], dp_b_w[g], dp_op_w[g]);
                    for (int k = 1; k < PP; k++) dl[k] <= dl[k-1];
                end
                assign {dp_co_w[g], dp_y_w[g]} = dl[PP-1];
            end
        end
    endgenerate

    // Reference model state
    trip_t q[$];
    bit    hv [HMAX];
    trip_t ht [HMAX];
    trip_t last_dp;
    int    edge_n   = 0;
    int    last_rst = -1;
    int    obs_res [NI];
    int    checks   = 0;
    int    failures = 0;

    function automatic bit popped(input int e);
        return (e >= 0) && (e > last_rst) && hv[e];
    endfunction

    task automatic chk(input string tag, input int p, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s pipe=%0d observed=%0h expected=%0h edge=%0d", tag, p, obs, exp, edge_n);
        end
    endtask

    task automatic check_inst(input int g);
        int         p;
        int         e;
        bit         exp_v;
        bit         busy;
        logic [N:0] r;
        p     = pipe_of(g);
        e     = edge_n - p;
        exp_v = popped(e);
        chk("res_valid", p, res_valid_w[g], exp_v);
        if (exp_v) begin
            r = dp_f(ht[e].a, ht[e].b, ht[e].op);
            chk("res_opcode", p, res_op_w[g], ht[e].op);
            chk("res_y", p, res_y_w[g], r[N-1:0]);
            chk("res_co", p, res_co_w[g], r[N]);
        end
        chk("fifo_count", p, cnt_w[g], q.size());
        chk("in_ready", p, in_ready_w[g], (q.size() < DEPTH));
        chk("dp_a", p, dp_a_w[g], last_dp.a);
        chk("dp_b", p, dp_b_w[g], last_dp.b);
        chk("dp_opcode", p, dp_op_w[g], last_dp.op);
        busy = 1'b0;
        for (int k = 0; k <= p; k++) busy = busy | popped(edge_n - k);
        chk("idle", p, idle_w[g], (q.size() == 0) && !busy);
        if (res_valid_w[g] === 1'b1) obs_res[g]++;
    endtask

    // Advance the model by one edge, clock the DUTs, then compare on the falling edge.
    task automatic tick();
        int    sz;
        trip_t t;
        edge_n++;
        if (edge_n >= HMAX) begin
            $display("FAIL edge_budget observed=%0d expected<%0d", edge_n, HMAX);
            $fatal(1);
        end
        hv[edge_n] = 1'b0;
        if (rst) begin
            q.delete();
            last_rst = edge_n;
            last_dp  = '0;
        end else begin
            sz = q.size();
            if (issue_en && sz > 0) begin
                t          = q.pop_front();
                hv[edge_n] = 1'b1;
                ht[edge_n] = t;
                last_dp    = t;
            end
            if (in_valid && sz < DEPTH) q.push_back({in_a, in_b, in_op});
        end
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) check_inst(g);
    endtask

    task automatic offer(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; issue_en = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        last_dp = '0;
        for (int g = 0; g < NI; g++) obs_res[g] = 0;
        @(negedge clk);

        // Reset and idle
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single operation
        issue_en = 1'b1;
        offer(16'd5, 16'd3, 3'd0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();

        // Fill to full with issue held off, then offer a ninth
        issue_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            offer(16'(i), 16'(i * 3), 3'(i));
            tick();
        end
        offer(16'd9, 16'd27, 3'd1);
        repeat (2) tick();
        in_valid = 1'b0;
        issue_en = 1'b1;
        repeat (12) tick();

        // Simultaneous push and pop at count 4, across pointer wrap
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(16'(16'h100 + i), 16'(i), 3'(i));
            tick();
        end
        issue_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(16'(16'h200 + i), 16'(16'hF000 + i), 3'(i + 2));
            tick();
        end
        in_valid = 1'b0;
        repeat (10) tick();

        // Reset mid-stream: 3 queued plus 1 in flight
        issue_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(16'(16'h300 + i), 16'd1, 3'd4);
            tick();
        end
        in_valid = 1'b0;
        issue_en = 1'b1;
        tick();
        issue_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue_en = 1'b1;
        offer(16'hFFF9, 16'd2, 3'd0);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();

        // Back-to-back stream of 20 random triples
        for (int g = 0; g < NI; g++) obs_res[g] = 0;
        issue_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            offer(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        for (int g = 0; g < NI; g++) chk("res_valid_count", pipe_of(g), obs_res[g], 20);

        // Random mix of traffic, stalls and occasional resets
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            issue_en = ($urandom_range(0, 2) != 0);
            rst      = ($urandom_range(0, 99) == 0);
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            in_op    = 3'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        issue_en = 1'b1;
        repeat (16) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
